// File: rtl/tick_sample_buffer.sv
// -----------------------------------------------------------------------------
// tick_sample_buffer
//
// Captures one audio sample on every rising edge of the interval timer's
// interrupt line and stores it in a 2^DEPTH_LOG2 entry FIFO. Software drains
// the FIFO through a 16-bit memory-mapped slave. An interrupt is raised once
// the fill level reaches a programmable threshold, so that samples can be
// serviced in batches rather than one per timer tick.
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-high reset
//   tick_in     timer irq level; a rising edge requests a capture
//   sample_in   audio sample taken in the cycle the edge is detected
//   address     register select (0 status, 1 control, 2 threshold, 3 level,
//               4 data/pop, 5 capture count, 6..7 reserved)
//   chipselect  slave select
//   read_n      active-low read strobe
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, valid the cycle after the strobe
//   irq         registered threshold interrupt
// -----------------------------------------------------------------------------
module tick_sample_buffer #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_in,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam int THR_W = 5;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // State
    logic                  tick_d_r;
    logic                  enable_r;
    logic                  irq_en_r;
    logic [THR_W-1:0]      threshold_r;
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [LVL_W-1:0]      level_r;
    logic                  overflow_r;
    logic [DATA_W-1:0]     count_r;
    logic [DATA_W-1:0]     readdata_r;
    logic                  irq_r;
    logic [DATA_W-1:0]     mem_r [DEPTH];

    // Decoded strobes and events
    logic              wr_s;
    logic              rd_s;
    logic              capture_s;
    logic              not_empty_s;
    logic              full_s;
    logic              flush_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic              irq_pending_s;
    logic [DATA_W-1:0] rdata_s;

    // Only the low control/threshold bits of a write have a destination.
    logic unused_s;
    assign unused_s = ^writedata[DATA_W-1:THR_W];

    assign readdata = readdata_r;
    assign irq      = irq_r;

    // Decode bus strobes, detect tick edges and classify FIFO events.
    always_comb begin
        wr_s        = chipselect & ~write_n;
        rd_s        = chipselect & ~read_n;
        capture_s   = tick_in & ~tick_d_r & enable_r;
        not_empty_s = (level_r != {LVL_W{1'b0}});
        full_s      = (level_r == FULL_LVL);
        flush_s     = wr_s & (address == 3'd1) & writedata[2];
        pop_s       = rd_s & (address == 3'd4) & not_empty_s;
        // A pop in the same cycle frees the slot a full FIFO needs.
        push_s      = capture_s & (~full_s | pop_s);
        // Overflow only counts samples lost to a full FIFO, not to a flush.
        drop_s      = capture_s & full_s & ~pop_s & ~flush_s;
        irq_pending_s = (threshold_r != {THR_W{1'b0}}) &
                        (32'(level_r) >= 32'(threshold_r));
    end

    // Read-data multiplexer for the register map.
    always_comb begin
        rdata_s = {DATA_W{1'b0}};
        case (address)
            3'd0: rdata_s[2:0] = {irq_pending_s, overflow_r, not_empty_s};
            3'd1: rdata_s[1:0] = {irq_en_r, enable_r};
            3'd2: rdata_s[THR_W-1:0] = threshold_r;
            3'd3: rdata_s[LVL_W-1:0] = level_r;
            3'd4: begin
                if (not_empty_s) begin
                    rdata_s = mem_r[rd_ptr_r];
                end else begin
                    rdata_s = {DATA_W{1'b0}};
                end
            end
            3'd5: rdata_s = count_r;
            default: rdata_s = {DATA_W{1'b0}};
        endcase
    end

    // Delayed tick level for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_d_r <= 1'b0;
        end else begin
            tick_d_r <= tick_in;
        end
    end

    // Control and threshold registers; flush bit is never stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_r    <= 1'b0;
            irq_en_r    <= 1'b0;
            threshold_r <= {THR_W{1'b0}};
        end else if (wr_s) begin
            case (address)
                3'd1: begin
                    enable_r <= writedata[0];
                    irq_en_r <= writedata[1];
                end
                3'd2: threshold_r <= writedata[THR_W-1:0];
                default: begin
                    enable_r    <= enable_r;
                    irq_en_r    <= irq_en_r;
                    threshold_r <= threshold_r;
                end
            endcase
        end
    end

    // FIFO pointers and fill level; a flush overrides any push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else if (flush_s) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + {{(LVL_W-1){1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{(LVL_W-1){1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

    // Sample storage; contents are only visible through a valid head pointer.
    always_ff @(posedge clk) begin
        if (push_s && !flush_s) begin
            mem_r[wr_ptr_r] <= sample_in;
        end
    end

    // Sticky overflow flag; a lost sample wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (wr_s && (address == 3'd0)) begin
            overflow_r <= 1'b0;
        end
    end

    // Count of accepted captures; software clear wins over an increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {DATA_W{1'b0}};
        end else if (wr_s && (address == 3'd5)) begin
            count_r <= {DATA_W{1'b0}};
        end else if (push_s && !flush_s) begin
            count_r <= count_r + {{(DATA_W-1){1'b0}}, 1'b1};
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_r <= {DATA_W{1'b0}};
        end else if (rd_s) begin
            readdata_r <= rdata_s;
        end
    end

    // Registered interrupt, one stage behind the fill level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_en_r & irq_pending_s;
        end
    end

endmodule

// File: tb/tb_tick_sample_buffer.sv
module tb_tick_sample_buffer;

    logic        clk;
    logic        reset;
    logic        tick_in;
    logic [15:0] sample_in;
    logic [2:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    int n_tests;
    int n_fail;

    tick_sample_buffer #(.DATA_W(16), .DEPTH_LOG2(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_in    (tick_in),
        .sample_in  (sample_in),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        tick;
        logic [15:0] sample;
        logic        rd;
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic        chk;
        logic [15:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [24];
    logic [15:0] rv;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        step();
        chipselect = 1'b0;
        read_n     = 1'b1;
        d = readdata;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_tick(input logic [15:0] s);
        tick_in   = 1'b1;
        sample_in = s;
        step();
        tick_in = 1'b0;
        step();
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        tick_in    = 1'b0;
        sample_in  = 16'h0000;
        address    = 3'd0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = 16'h0000;

        //             tick  sample    rd    wr    addr  wdata     chk   exp_rd    irq
        vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 3'd1, 16'h0003, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 3'd2, 16'h0004, 1'b0, 16'h0000, 1'b0};
        vecs[2]  = '{1'b1, 16'h0101, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, 16'h0102, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[6]  = '{1'b1, 16'h0103, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[8]  = '{1'b1, 16'h0104, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 16'h0000, 1'b1, 16'h0004, 1'b1};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0005, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd4, 16'h0000, 1'b1, 16'h0101, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd4, 16'h0000, 1'b1, 16'h0102, 1'b0};
        vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd4, 16'h0000, 1'b1, 16'h0103, 1'b0};
        vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd4, 16'h0000, 1'b1, 16'h0104, 1'b0};
        vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd4, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd5, 16'h0000, 1'b1, 16'h0004, 1'b0};
        vecs[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd1, 16'h0000, 1'b1, 16'h0003, 1'b0};
        vecs[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd2, 16'h0000, 1'b1, 16'h0004, 1'b0};
        vecs[20] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[21] = '{1'b0, 16'h0000, 1'b0, 1'b1, 3'd5, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[22] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd5, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[23] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000, 1'b0};

        // Reset state
        step();
        step();
        check("reset_readdata", readdata, 16'h0000);
        check("reset_irq", {15'h0, irq}, 16'h0000);
        reset = 1'b0;
        step();

        // Table: batch of four captures, threshold irq, in-order drain
        for (int i = 0; i < 24; i++) begin
            tick_in    = vecs[i].tick;
            sample_in  = vecs[i].sample;
            chipselect = vecs[i].rd | vecs[i].wr;
            read_n     = ~vecs[i].rd;
            write_n    = ~vecs[i].wr;
            address    = vecs[i].addr;
            writedata  = vecs[i].wdata;
            step();
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_irq", i), {15'h0, irq}, {15'h0, vecs[i].exp_irq});
        end
        tick_in    = 1'b0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;

        // Level held high gives one capture
        tick_in   = 1'b1;
        sample_in = 16'h0AAA;
        for (int i = 0; i < 10; i++) step();
        tick_in = 1'b0;
        step();
        bus_read(3'd3, rv); check("hold_level", rv, 16'h0001);
        bus_read(3'd5, rv); check("hold_count", rv, 16'h0001);
        bus_read(3'd4, rv); check("hold_data", rv, 16'h0AAA);

        // Fill to 16, then overflow on the 17th
        bus_write(3'd2, 16'h0000);
        for (int i = 0; i < 16; i++) do_tick(16'h1000 + 16'(i));
        bus_read(3'd3, rv); check("full_level", rv, 16'h0010);
        do_tick(16'h2222);
        bus_read(3'd0, rv); check("ovf_status", rv, 16'h0003);
        bus_read(3'd3, rv); check("ovf_level", rv, 16'h0010);
        bus_read(3'd5, rv); check("ovf_count", rv, 16'h0011);
        bus_write(3'd0, 16'h0000);
        bus_read(3'd0, rv); check("ovf_cleared", rv, 16'h0001);
        check("irq_thr0", {15'h0, irq}, 16'h0000);
        bus_write(3'd2, 16'h0010);
        step();
        check("irq_thr16", {15'h0, irq}, 16'h0001);
        bus_write(3'd1, 16'h0001);
        step();
        check("irq_en_clear", {15'h0, irq}, 16'h0000);
        bus_write(3'd2, 16'h0000);

        // Full FIFO: tick edge and data read in the same cycle
        tick_in    = 1'b1;
        sample_in  = 16'h3333;
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = 3'd4;
        step();
        chipselect = 1'b0;
        read_n     = 1'b1;
        tick_in    = 1'b0;
        check("full_pop_data", readdata, 16'h1000);
        step();
        bus_read(3'd3, rv); check("full_pushpop_level", rv, 16'h0010);
        bus_read(3'd0, rv); check("full_pushpop_status", rv, 16'h0001);
        for (int i = 1; i < 16; i++) begin
            bus_read(3'd4, rv);
            check($sformatf("drain%0d", i), rv, 16'h1000 + 16'(i));
        end
        bus_read(3'd4, rv); check("drain_last", rv, 16'h3333);
        bus_read(3'd3, rv); check("drained_level", rv, 16'h0000);

        // Empty read, then flush at level 5 with a coincident tick
        bus_read(3'd4, rv); check("empty_read", rv, 16'h0000);
        bus_read(3'd3, rv); check("empty_level", rv, 16'h0000);
        do_tick(16'h4444);
        bus_read(3'd4, rv); check("after_empty_head", rv, 16'h4444);
        for (int i = 0; i < 5; i++) do_tick(16'h5000 + 16'(i));
        bus_read(3'd3, rv); check("pre_flush_level", rv, 16'h0005);
        tick_in    = 1'b1;
        sample_in  = 16'h6666;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd1;
        writedata  = 16'h0005;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        tick_in    = 1'b0;
        step();
        bus_read(3'd3, rv); check("flush_level", rv, 16'h0000);
        bus_read(3'd0, rv); check("flush_status", rv, 16'h0000);
        bus_read(3'd5, rv); check("flush_count", rv, 16'h0018);
        bus_read(3'd1, rv); check("flush_ctrl", rv, 16'h0001);
        do_tick(16'h7777);
        bus_read(3'd4, rv); check("post_flush_data", rv, 16'h7777);

        // Asynchronous reset with level 7
        bus_write(3'd2, 16'h0004);
        bus_write(3'd1, 16'h0003);
        for (int i = 0; i < 7; i++) do_tick(16'h8000 + 16'(i));
        bus_read(3'd3, rv); check("prereset_level", rv, 16'h0007);
        check("prereset_irq", {15'h0, irq}, 16'h0001);
        tick_in = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async_readdata", readdata, 16'h0000);
        check("async_irq", {15'h0, irq}, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_read(3'd3, rv); check("postreset_level", rv, 16'h0000);
        bus_read(3'd1, rv); check("postreset_ctrl", rv, 16'h0000);
        bus_write(3'd1, 16'h0001);
        step();
        bus_read(3'd3, rv); check("held_tick_no_capture", rv, 16'h0000);
        tick_in = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
